mul8x8_seq: RTL and testbench
=============================

MUL8X8_SEQ -- requirements
Module: mul8x8_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  Reset, synchronous, active-low; sampled on the rising clk edge.
REQ-004 start  input  1  Request to begin a multiply; honoured only while busy=0.
REQ-005 a  input  8  Multiplicand, unsigned; sampled only when start is accepted.
REQ-006 b  input  8  Multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  High while a multiply is in progress; start is ignored while it is high.
REQ-008 done  output  1  One-cycle pulse; res holds a new valid product during this cycle.
REQ-009 res  output  16  Unsigned product a*b of the last completed operation, registered.

Function
REQ-010 The block SHALL instantiate exactly one mul4x4 (4x4 -> 8-bit unsigned, combinational) and compute the 8x8 product by time-sharing it over 4 cycles.
REQ-011 The FSM SHALL have states IDLE, MUL and DONE, plus a 2-bit step counter used in MUL.
REQ-012 Start acceptance: in IDLE or DONE with start=1, latch a and b into internal registers, clear the 16-bit accumulator, set step=0 and go to MUL.
REQ-013 In IDLE or DONE with start=0, the FSM SHALL go to IDLE (DONE lasts exactly one cycle).
REQ-014 Each MUL cycle SHALL present one nibble pair to mul4x4 and add the 8-bit partial product, zero-extended and shifted, to the accumulator.
REQ-015 step 0: a[3:0]*b[3:0], shift 0.
REQ-016 step 1: a[7:4]*b[3:0], shift 4.
REQ-017 step 2: a[3:0]*b[7:4], shift 4.
REQ-018 step 3: a[7:4]*b[7:4], shift 8.
REQ-019 Accumulation SHALL be 16-bit modulo; no overflow can occur because 255*255 = 0xFE01.
REQ-020 On the step-3 edge, the final sum SHALL be written to res and the FSM SHALL go to DONE; steps 0-2 increment step and stay in MUL.
REQ-021 busy SHALL be 1 exactly while in MUL, and done SHALL be 1 exactly while in DONE.
REQ-022 Latency: start accepted at edge k -> accumulation at edges k+1..k+4 -> done=1 and new res in the cycle after edge k+4.
REQ-023 Throughput: start held high in the DONE cycle SHALL be accepted, giving one result per 5 cycles back-to-back.
REQ-024 start in MUL SHALL be ignored, with no effect on the operands, step, accumulator or res.
REQ-025 Changes on a/b after acceptance SHALL NOT affect the operation in progress.
REQ-026 res SHALL change only on entry to DONE and SHALL hold its value in all other cycles, including during a following operation.

Reset
REQ-027 When rst_n=0 at a clk edge: state=IDLE, step=0, accumulator=0, operand registers=0, res=0x0000, busy=0, done=0.
REQ-028 Reset asserted mid-operation (MUL or DONE) SHALL abort it: no done pulse is produced and res reads 0x0000.
REQ-029 Reset SHALL take priority over start in the same cycle.
REQ-030 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-031 a=0x12, b=0x34, start for 1 cycle -> busy=1 for 4 cycles, then done=1 for 1 cycle with res=0x03A8; res then holds 0x03A8.
REQ-032 Corner values -> 0xFF*0xFF gives res=0xFE01; 0x0F*0x0F gives 0x00E1; 0x00*0xAB gives 0x0000; 0x80*0x02 gives 0x0100.
REQ-033 Start 0x03*0x05, then pulse start with a=0xFF, b=0xFF during MUL -> single done pulse with res=0x000F; no second operation runs.
REQ-034 Start 0x10*0x10 and hold start=1 with a/b changed to 0x02*0x03 in the DONE cycle -> res=0x0100 at the first done, then res=0x0006 exactly 5 cycles later.
REQ-035 Start 0xAA*0x55, then drive rst_n=0 for 1 cycle at step 2 -> busy=0, done never pulses, res=0x0000; a subsequent 0x07*0x09 gives 0x003F.
REQ-036 Random regression -> 10,000 random a/b pairs with random start gaps; every done pulse SHALL match a*b against a reference model.

Source files
------------

// File: rtl/mul8x8_seq.sv
// Sequential 8x8 unsigned multiplier that time-shares one 4x4 array
// multiplier over four nibble-pair steps, one partial product per cycle.

module mul4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [7:0] row0;
  logic [7:0] row1;
  logic [7:0] row2;
  logic [7:0] row3;

  always_comb begin
    row0 = y[0] ? {4'b0, x}       : 8'h00;
    row1 = y[1] ? {3'b0, x, 1'b0} : 8'h00;
    row2 = y[2] ? {2'b0, x, 2'b0} : 8'h00;
    row3 = y[3] ? {1'b0, x, 3'b0} : 8'h00;
    p    = row0 + row1 + row2 + row3;
  end

endmodule

module mul8x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  step_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc_q;
  logic [15:0] res_q;

  logic        accept;
  logic        in_mul;
  logic        last_step;
  logic [3:0]  nib_x;
  logic [3:0]  nib_y;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] acc_sum;

  assign in_mul    = (state_q == MUL);
  assign accept    = !in_mul && start;
  assign last_step = in_mul && (step_q == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE always falls back to IDLE unless restarted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE,
      DONE: state_d = start ? MUL : IDLE;
      MUL:  state_d = (step_q == 2'd3) ? DONE : MUL;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == MUL);
    done = (state_q == DONE);
    res  = res_q;
  end

  // Nibble pair for the current step
  always_comb begin
    nib_x = a_q[3:0];
    nib_y = b_q[3:0];
    unique case (step_q)
      2'd0: begin nib_x = a_q[3:0]; nib_y = b_q[3:0]; end
      2'd1: begin nib_x = a_q[7:4]; nib_y = b_q[3:0]; end
      2'd2: begin nib_x = a_q[3:0]; nib_y = b_q[7:4]; end
      2'd3: begin nib_x = a_q[7:4]; nib_y = b_q[7:4]; end
      default: begin nib_x = 4'h0; nib_y = 4'h0; end
    endcase
  end

  mul4x4 u_mul4x4 (
    .x (nib_x),
    .y (nib_y),
    .p (pp)
  );

  // Weight of the partial product: cross terms share shift 4
  always_comb begin
    pp_sh = {8'h00, pp};
    unique case (step_q)
      2'd0:    pp_sh = {8'h00, pp};
      2'd1,
      2'd2:    pp_sh = {4'h0, pp, 4'h0};
      2'd3:    pp_sh = {pp, 8'h00};
      default: pp_sh = 16'h0000;
    endcase
    acc_sum = acc_q + pp_sh;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= 2'd0;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      acc_q  <= 16'h0000;
      res_q  <= 16'h0000;
    end else if (accept) begin
      step_q <= 2'd0;
      a_q    <= a;
      b_q    <= b;
      acc_q  <= 16'h0000;
    end else if (in_mul) begin
      step_q <= step_q + 2'd1;
      acc_q  <= acc_sum;
      if (last_step) begin
        res_q <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mul8x8_seq.sv
// Randomized self-checking bench for mul8x8_seq against a plain
// arithmetic product model with cycle-exact busy/done expectations.

module tb_mul8x8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] res;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_res = 16'h0000;

  mul8x8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_res", 32'(res), 32'(exp_res));
    end
  endtask

  // mode 0: quiet during MUL, 1: start pulse with 0xFF operands,
  // 2: random start and operands during MUL
  task automatic op(input logic [7:0] x,
                    input logic [7:0] y,
                    input int mode);
    a     = x;
    b     = y;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_done", 32'(done), 32'd0);
      chk("mul_res_hold", 32'(res), 32'(exp_res));
      if (mode == 1) begin
        start = (c == 0);
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
    end
    tick();
    exp_res = {8'h00, x} * {8'h00, y};
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_res", 32'(res), 32'(exp_res));
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);

    // Reset wins over a simultaneous start
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h55;
    tick();
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_res", 32'(res), 32'd0);

    // First edge out of reset accepts start
    rst_n = 1'b1;
    op(8'h12, 8'h34, 0);
    chk("basic_res", 32'(res), 32'h03A8);
    idle(3);
    chk("basic_hold", 32'(res), 32'h03A8);

    op(8'hFF, 8'hFF, 0);
    chk("corner_ffff", 32'(res), 32'hFE01);
    idle(1);
    op(8'h0F, 8'h0F, 0);
    chk("corner_0f0f", 32'(res), 32'h00E1);
    idle(1);
    op(8'h00, 8'hAB, 0);
    chk("corner_zero", 32'(res), 32'h0000);
    idle(1);
    op(8'h80, 8'h02, 0);
    chk("corner_8002", 32'(res), 32'h0100);
    idle(1);

    // Start during MUL is ignored, no second operation follows
    op(8'h03, 8'h05, 1);
    chk("ignore_res", 32'(res), 32'h000F);
    idle(6);

    // Back-to-back: restart in the DONE cycle
    op(8'h10, 8'h10, 0);
    chk("b2b_first", 32'(res), 32'h0100);
    op(8'h02, 8'h03, 0);
    chk("b2b_second", 32'(res), 32'h0006);
    idle(1);

    // Abort with reset on the step-2 edge
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    tick();
    chk("abort_busy0", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_res = 16'h0000;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'(res), 32'h0000);
    rst_n = 1'b1;
    idle(4);
    op(8'h07, 8'h09, 0);
    chk("after_abort", 32'(res), 32'h003F);
    idle(1);

    for (int n = 0; n < 10000; n++) begin
      op(8'($urandom), 8'($urandom), 2);
      if ($urandom_range(0, 2) != 0) begin
        idle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
